glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
- Timing controller directly upstream of the glitch output stage.
- Waits for an external trigger edge, counts a programmable delay in clk_in cycles, then drives en high for a programmable width.
- Repeats that pulse a programmable number of times with a programmable gap between pulses.
- Holds a latched mode word stable throughout, so the output stage sees constant en/mode per pulse.

Parameters:
- CNT_W, 16: width of the delay, width and gap counters and their config inputs.
- REP_W, 8: width of the repeat count and its config input.

Ports:
- clk_in  input  1  sequencer clock; the target clock the output stage glitches.
- rst_n  input  1  reset, asynchronous, active-low.
- arm  input  1  single-cycle request to arm; captures all config inputs.
- abort  input  1  synchronous cancel; returns to IDLE.
- trigger  input  1  external trigger; the rising edge starts a sequence.
- cfg_delay  input  CNT_W  cycles from trigger edge to first pulse.
- cfg_width  input  CNT_W  pulse width in cycles; 0 treated as 1.
- cfg_gap  input  CNT_W  low cycles between pulses; 0 treated as 1.
- cfg_count  input  REP_W  number of pulses; 0 treated as 1.
- cfg_mode  input  8  mode word for the output stage.
- en  output  1  glitch enable to the output stage, registered.
- mode  output  8  latched mode word, registered.
- armed  output  1  high while waiting for trigger.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on sequence completion.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, en=0, mode=8'h00, armed=0, busy=0, done=0; all counters and trig_q cleared.
- All state updates occur on the rising edge of clk_in. Every output is a register; none is combinational from inputs.
- trig_q: registered copy of trigger (after the optional synchronizer), updated every cycle in every state. A trigger edge is a sample with trigger=1 and trig_q=0.
- IDLE:
  - arm=1 latches cfg_* into shadow registers and cfg_mode into mode, then goes to ARMED.
  - Zero-valued width, gap and count are substituted with 1 at latch time.
- ARMED:
  - armed=1.
  - A trigger edge sampled at edge k goes to DELAY with the delay counter loaded from the shadow delay.
  - If trigger is already high at arm, it must fall and rise again before the sequence fires.
- DELAY: decrements each cycle. en rises at edge k+delay+1; delay=0 means en is high from edge k+1.
- GLITCH: en=1 for exactly width cycles. On the last cycle, the pulse counter decrements:
  - if pulses remain, go to GAP;
  - otherwise go to DONE.
- GAP: en=0 for exactly gap cycles, then GLITCH.
- DONE: done=1 for one cycle, en=0, then IDLE. mode retains its last value until the next arm.
- abort=1 in any non-IDLE state: at the next edge state=IDLE, en=0, done stays 0. abort in IDLE has no effect.
- Simultaneous arm and abort in IDLE: arm wins.
- arm while busy is ignored; shadow registers are untouched.
- Counters never wrap: all loads are ≥1 except delay, and terminal detection occurs at value 1 (delay: 0).
- Total en-high cycles = width × count. Total sequence from trigger edge to done = delay + count×width + (count−1)×gap + 1 cycles.

Optional Feature:
- GLITCH_TRIG_SYNC_EN
- Defined: trigger passes through a two-flop synchronizer (reset 0) before edge detection. Edge-to-en latency increases by 2 cycles; all other timing is unchanged.
- Undefined: trigger feeds edge detection directly; caller guarantees it is synchronous to clk_in.

Test Plan:
- Basic pulse: arm with delay=3, width=2, count=1, mode=8'h08; trigger rises at edge 10 → en high at edges 14–15, done at edge 16, mode=8'h08 from edge after arm.
- Repeated pulses: delay=0, width=1, gap=2, count=3; trigger edge at k → en high at k+1, k+4, k+7; done at k+8; busy low at k+9.
- Zero substitution and stuck trigger: width=0, count=0, gap=0, trigger held high through arm → no en until trigger falls then rises. Then en high for exactly 1 cycle, done the following cycle.
- Abort: count=2, width=5; assert abort on the third en-high cycle → en low at the next edge, state IDLE, done never pulses. A second trigger edge produces no en.
- Reset mid-operation: drop rst_n during GAP → en, armed, busy, done, mode all 0 immediately, without a clock edge. After release, trigger edges are ignored until re-armed.
- With GLITCH_TRIG_SYNC_EN defined: repeat the basic pulse test → en high at edges 16–17, done at 18.

Source files
------------

// File: rtl/glitch_sequencer.sv
// Trigger-to-pulse timing controller feeding the glitch output stage.
// Define GLITCH_TRIG_SYNC_EN to pass trigger through a two-flop synchronizer.
module glitch_sequencer #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_count,
    input  logic [7:0]       cfg_mode,
    output logic             en,
    output logic [7:0]       mode,
    output logic             armed,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_GLITCH,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    logic trig_s;

`ifdef GLITCH_TRIG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], trigger};
        end
    end

    assign trig_s = sync_q[1];
`else
    assign trig_s = trigger;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] sh_delay_q, sh_delay_d;
    logic [CNT_W-1:0] sh_width_q, sh_width_d;
    logic [CNT_W-1:0] sh_gap_q, sh_gap_d;
    logic [REP_W-1:0] sh_count_q, sh_count_d;
    logic [7:0]       mode_q, mode_d;
    logic             en_q, en_d;
    logic             armed_q, armed_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             trig_q;
    logic             trig_edge;

    assign trig_edge = trig_s & ~trig_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pcnt_d     = pcnt_q;
        sh_delay_d = sh_delay_q;
        sh_width_d = sh_width_q;
        sh_gap_d   = sh_gap_q;
        sh_count_d = sh_count_q;
        mode_d     = mode_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    sh_delay_d = cfg_delay;
                    sh_width_d = (cfg_width == '0) ? CNT_ONE : cfg_width;
                    sh_gap_d   = (cfg_gap == '0) ? CNT_ONE : cfg_gap;
                    sh_count_d = (cfg_count == '0) ? REP_ONE : cfg_count;
                    mode_d     = cfg_mode;
                    state_d    = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trig_edge) begin
                    cnt_d   = sh_delay_q;
                    pcnt_d  = sh_count_q;
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    cnt_d   = sh_width_q;
                    state_d = S_GLITCH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GLITCH: begin
                if (cnt_q == CNT_ONE) begin
                    if (pcnt_q == REP_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        pcnt_d  = pcnt_q - REP_ONE;
                        cnt_d   = sh_gap_q;
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = sh_width_q;
                    state_d = S_GLITCH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        // Outputs are decoded from the next state so they register alongside it.
        en_d    = (state_d == S_GLITCH);
        armed_d = (state_d == S_ARMED);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pcnt_q     <= '0;
            sh_delay_q <= '0;
            sh_width_q <= '0;
            sh_gap_q   <= '0;
            sh_count_q <= '0;
            mode_q     <= '0;
            en_q       <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            sh_delay_q <= sh_delay_d;
            sh_width_q <= sh_width_d;
            sh_gap_q   <= sh_gap_d;
            sh_count_q <= sh_count_d;
            mode_q     <= mode_d;
            en_q       <= en_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            trig_q     <= trig_s;
        end
    end

    assign en    = en_q;
    assign mode  = mode_q;
    assign armed = armed_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer; expected waveforms are hand-computed
// bit histories indexed by cycles after the trigger edge.
module tb_glitch_sequencer;

`ifdef GLITCH_TRIG_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk_in  = 1'b0;
    logic        rst_n   = 1'b1;
    logic        arm     = 1'b0;
    logic        abort   = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] cfg_delay = '0;
    logic [15:0] cfg_width = '0;
    logic [15:0] cfg_gap   = '0;
    logic [7:0]  cfg_count = '0;
    logic [7:0]  cfg_mode  = '0;
    logic        en;
    logic [7:0]  mode;
    logic        armed;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] en_h, done_h, busy_h;

    glitch_sequencer #(
        .CNT_W(16),
        .REP_W(8)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .arm      (arm),
        .abort    (abort),
        .trigger  (trigger),
        .cfg_delay(cfg_delay),
        .cfg_width(cfg_width),
        .cfg_gap  (cfg_gap),
        .cfg_count(cfg_count),
        .cfg_mode (cfg_mode),
        .en       (en),
        .mode     (mode),
        .armed    (armed),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic arm_seq(input logic [15:0] d, input logic [15:0] w, input logic [15:0] g,
                           input logic [7:0] c, input logic [7:0] m);
        cfg_delay = d;
        cfg_width = w;
        cfg_gap   = g;
        cfg_count = c;
        cfg_mode  = m;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Bit i of each history holds the output after the (i+1)-th edge from now.
    task automatic capture(input int n);
        en_h   = '0;
        done_h = '0;
        busy_h = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            en_h[i]   = en;
            done_h[i] = done;
            busy_h[i] = busy;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check_eq("reset_outs", {19'd0, en, armed, busy, done, 1'b0, mode}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic pulse: delay=3, width=2, count=1
        arm_seq(16'd3, 16'd2, 16'd1, 8'd1, 8'h08);
        check_eq("basic_mode", {24'd0, mode}, 32'h08);
        check_eq("basic_armed", {30'd0, armed, busy}, 32'h3);
        tick();
        tick();
        trigger = 1'b1;
        tick();
        check_eq("basic_en_at_k", {31'd0, en}, 32'h0);
        capture(12);
        check_eq("basic_en", en_h, 32'h18 << LAT);
        check_eq("basic_done", done_h, 32'h20 << LAT);
        check_eq("basic_busy", busy_h, (32'd1 << (6 + LAT)) - 32'd1);
        check_eq("basic_mode_hold", {24'd0, mode}, 32'h08);
        trigger = 1'b0;
        tick();

        // Repeated pulses: delay=0, width=1, gap=2, count=3
        arm_seq(16'd0, 16'd1, 16'd2, 8'd3, 8'h21);
        tick();
        trigger = 1'b1;
        tick();
        capture(12);
        check_eq("rep_en", en_h, 32'h49 << LAT);
        check_eq("rep_done", done_h, 32'h80 << LAT);
        check_eq("rep_busy", busy_h, (32'd1 << (8 + LAT)) - 32'd1);
        trigger = 1'b0;
        tick();

        // Zero substitution with trigger stuck high through arm
        trigger = 1'b1;
        tick();
        tick();
        tick();
        arm_seq(16'd1, 16'd0, 16'd0, 8'd0, 8'h44);
        capture(5);
        check_eq("stuck_no_en", en_h, 32'h0);
        check_eq("stuck_armed", {31'd0, armed}, 32'h1);
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        capture(8);
        check_eq("zero_en", en_h, 32'h2 << LAT);
        check_eq("zero_done", done_h, 32'h4 << LAT);
        trigger = 1'b0;
        tick();

        // Abort on third en-high cycle; arm while busy is ignored
        arm_seq(16'd0, 16'd5, 16'd1, 8'd2, 8'h5A);
        tick();
        trigger = 1'b1;
        tick();
        for (int i = 0; i < LAT + 1; i++) tick();
        check_eq("abort_en1", {31'd0, en}, 32'h1);
        cfg_mode = 8'hFF;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_eq("busy_arm_ignored", {24'd0, mode}, 32'h5A);
        tick();
        check_eq("abort_en3", {31'd0, en}, 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_outs", {28'd0, en, armed, busy, done}, 32'h0);
        capture(8);
        check_eq("abort_no_done", done_h, 32'h0);
        check_eq("abort_no_en", en_h, 32'h0);
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        capture(8);
        check_eq("abort_retrig_en", en_h, 32'h0);
        check_eq("abort_retrig_busy", busy_h, 32'h0);
        trigger = 1'b0;
        tick();

        // Arm and abort together in IDLE: arm wins
        cfg_delay = 16'd0;
        cfg_width = 16'd1;
        cfg_gap   = 16'd4;
        cfg_count = 8'd2;
        cfg_mode  = 8'hC3;
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check_eq("arm_abort_idle", {23'd0, armed, mode}, 32'h1C3);

        // Asynchronous reset during GAP
        tick();
        trigger = 1'b1;
        tick();
        for (int i = 0; i < LAT + 1; i++) tick();
        check_eq("rst_pre_en", {31'd0, en}, 32'h1);
        tick();
        tick();
        check_eq("rst_in_gap", {30'd0, en, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset", {19'd0, en, armed, busy, done, 1'b0, mode}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        capture(10);
        check_eq("post_rst_en", en_h, 32'h0);
        check_eq("post_rst_busy", busy_h, 32'h0);
        check_eq("post_rst_armed", {31'd0, armed}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
